// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the word-serial interface and the core.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } wif_state_e;

endpackage

// File: rtl/aes128_word_if.sv
// Word-serial front end for the AES-128 core: packs key/plaintext words, starts the
// core, unpacks the ciphertext over valid/ready and watches for a hung core.
module aes128_word_if
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid_i,
    input  logic [AES_WORD_W-1:0]  key_data_i,
    output logic                   key_ready_o,
    input  logic                   s_valid_i,
    input  logic [AES_WORD_W-1:0]  s_data_i,
    output logic                   s_ready_o,
    output logic                   m_valid_o,
    output logic [AES_WORD_W-1:0]  m_data_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic                   key_loaded_o,
    output logic                   err_o,
    input  logic                   err_clr_i,
    output logic                   core_start_o,
    output logic [AES_BLOCK_W-1:0] core_key_o,
    output logic [AES_BLOCK_W-1:0] core_pt_o,
    input  logic                   core_ready_i,
    input  logic                   core_done_i,
    input  logic [AES_BLOCK_W-1:0] core_ct_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    wif_state_e             r_state;
    wif_state_e             w_state_nxt;
    logic [AES_BLOCK_W-1:0] r_key;
    logic [AES_BLOCK_W-1:0] r_pt;
    logic [AES_BLOCK_W-1:0] r_ct;
    logic [1:0]             r_key_cnt;
    logic [1:0]             r_o_cnt;
    logic [2:0]             r_pt_cnt;
    logic [2:0]             w_pt_cnt_nxt;
    logic [15:0]            r_tmo_cnt;
    logic                   r_key_loaded;
    logic                   r_err;
    logic                   r_key_rdy;
    logic                   r_s_rdy;
    logic                   w_key_wr;
    logic                   w_pt_wr;
    logic                   w_pt_full;
    logic                   w_abort;
    logic                   w_m_hs;
    logic                   w_m_last_hs;

    assign w_key_wr    = key_valid_i && r_key_rdy;
    assign w_pt_wr     = s_valid_i && r_s_rdy;
    // Look ahead at the word being accepted so START follows the last word directly.
    assign w_pt_full   = (r_pt_cnt == 3'd4) || ((r_pt_cnt == 3'd3) && w_pt_wr);
    assign w_abort     = (r_state == BUSY) && !core_done_i && (r_tmo_cnt == TMO_LAST);
    assign w_m_hs      = (r_state == DRAIN) && m_ready_i;
    assign w_m_last_hs = w_m_hs && (r_o_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pt_full && r_key_loaded && !w_key_wr && core_ready_i) begin
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = BUSY;
            BUSY: begin
                if (core_done_i) begin
                    w_state_nxt = DRAIN;
                end else if (w_abort) begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (w_m_last_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start_o = (r_state == START);
        m_valid_o    = (r_state == DRAIN);
        m_last_o     = (r_state == DRAIN) && (r_o_cnt == 2'd3);
        w_pt_cnt_nxt = r_pt_cnt;
        if (w_pt_wr) begin
            w_pt_cnt_nxt = r_pt_cnt + 3'd1;
        end
        if (w_abort || w_m_last_hs) begin
            w_pt_cnt_nxt = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key        <= '0;
            r_pt         <= '0;
            r_ct         <= '0;
            r_key_cnt    <= 2'd0;
            r_o_cnt      <= 2'd0;
            r_pt_cnt     <= 3'd0;
            r_tmo_cnt    <= 16'd0;
            r_key_loaded <= 1'b0;
            r_err        <= 1'b0;
            r_key_rdy    <= 1'b0;
            r_s_rdy      <= 1'b0;
        end else begin
            // Ready flags are registered so they stay low while reset is held.
            r_key_rdy <= (w_state_nxt == IDLE);
            r_s_rdy   <= (w_state_nxt == IDLE) && (w_pt_cnt_nxt < 3'd4);
            r_pt_cnt  <= w_pt_cnt_nxt;
            if (w_key_wr) begin
                r_key     <= {r_key[AES_BLOCK_W-AES_WORD_W-1:0], key_data_i};
                r_key_cnt <= r_key_cnt + 2'd1;
                if (r_key_cnt == 2'd0) begin
                    r_key_loaded <= 1'b0;
                end
                if (r_key_cnt == 2'd3) begin
                    r_key_loaded <= 1'b1;
                end
            end
            if (w_pt_wr) begin
                r_pt <= {r_pt[AES_BLOCK_W-AES_WORD_W-1:0], s_data_i};
            end
            if (r_state == START) begin
                r_tmo_cnt <= 16'd0;
            end else if (r_state == BUSY) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if ((r_state == BUSY) && core_done_i) begin
                r_ct    <= core_ct_i;
                r_o_cnt <= 2'd0;
            end else if (w_m_hs) begin
                r_ct    <= {r_ct[AES_BLOCK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
                r_o_cnt <= r_o_cnt + 2'd1;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign key_ready_o  = r_key_rdy;
    assign s_ready_o    = r_s_rdy;
    assign m_data_o     = r_ct[AES_BLOCK_W-1 -: AES_WORD_W];
    assign key_loaded_o = r_key_loaded;
    assign err_o        = r_err;
    assign core_key_o   = r_key;
    assign core_pt_o    = r_pt;

endmodule

// File: tb/tb_aes128_word_if.sv
// Scoreboard bench for aes128_word_if with a latency-programmable AES core stub.
module tb_aes128_word_if;

    localparam int TMO = 8;
    localparam logic [127:0] FIPS_K = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_P = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] FIPS_C = 128'h3925841d_02dc09fb_dc118597_196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid_i = 1'b0;
    logic [31:0]  key_data_i = '0;
    logic         key_ready_o;
    logic         s_valid_i = 1'b0;
    logic [31:0]  s_data_i = '0;
    logic         s_ready_o;
    logic         m_valid_o;
    logic [31:0]  m_data_o;
    logic         m_last_o;
    logic         m_ready_i = 1'b1;
    logic         key_loaded_o;
    logic         err_o;
    logic         err_clr_i = 1'b0;
    logic         core_start_o;
    logic [127:0] core_key_o;
    logic [127:0] core_pt_o;
    logic         core_ready_i;
    logic         core_done_i;
    logic [127:0] core_ct_i;

    always #5 clk = ~clk;

    aes128_word_if #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid_i(key_valid_i), .key_data_i(key_data_i), .key_ready_o(key_ready_o),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .key_loaded_o(key_loaded_o), .err_o(err_o), .err_clr_i(err_clr_i),
        .core_start_o(core_start_o), .core_key_o(core_key_o), .core_pt_o(core_pt_o),
        .core_ready_i(core_ready_i), .core_done_i(core_done_i), .core_ct_i(core_ct_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: FIPS-197 answer for the reference vector, a keyed mix otherwise.
    function automatic logic [127:0] ref_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_K && p == FIPS_P) return FIPS_C;
        return k ^ {p[63:0], p[127:64]} ^ 128'h01234567_89abcdef_fedcba98_76543210;
    endfunction

    // Core stub: done after stub_lat cycles; stub_lat == 0 means it hangs.
    int           stub_lat = 3;
    logic         stub_kick = 1'b0;
    logic         stub_busy;
    int           stub_cnt;
    logic [127:0] stub_k, stub_p;
    assign core_ready_i = !stub_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy   <= 1'b0;
            stub_cnt    <= 0;
            stub_k      <= '0;
            stub_p      <= '0;
            core_done_i <= 1'b0;
            core_ct_i   <= '0;
        end else begin
            core_done_i <= 1'b0;
            if (core_start_o) begin
                stub_busy <= 1'b1;
                stub_cnt  <= stub_lat;
                stub_k    <= core_key_o;
                stub_p    <= core_pt_o;
            end else if (stub_kick) begin
                stub_busy <= 1'b0;
            end else if (stub_busy && stub_cnt == 1) begin
                core_done_i <= 1'b1;
                core_ct_i   <= ref_ct(stub_k, stub_p);
                stub_busy   <= 1'b0;
            end else if (stub_busy && stub_cnt > 1) begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;
    exp_t q[$];

    int   cyc = 0;
    int   start_cnt = 0, start_cyc = -100, done_cyc = -100, kl_cyc = -100, last_hs_cyc = -100;
    logic bp_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic push_block(input logic [127:0] c);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.d    = c[127-32*i -: 32];
            e.last = (i == 3);
            q.push_back(e);
        end
    endtask

    // Monitor: drives m_ready_i, then samples just after the falling edge.
    initial begin
        logic        prev_stall = 1'b0, prev_valid = 1'b0, prev_kl = 1'b0, prev_last = 1'b0;
        logic [31:0] prev_d = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            m_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
                prev_kl    = 1'b0;
            end else begin
                if (core_start_o) begin
                    start_cnt++;
                    start_cyc = cyc;
                end
                if (core_done_i) done_cyc = cyc;
                if (key_loaded_o && !prev_kl) kl_cyc = cyc;
                if (m_valid_o && !prev_valid)
                    check("first_word_latency", 128'(cyc), 128'(done_cyc + 1));
                if (prev_stall)
                    check("stall_hold", {95'd0, m_valid_o, m_last_o, m_data_o}, {95'd0, 1'b1, prev_last, prev_d});
                if (m_valid_o && m_ready_i) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got %h with last=%b, expected no output", m_data_o, m_last_o);
                    end else begin
                        e = q.pop_front();
                        check("ct_word", {95'd0, m_last_o, m_data_o}, {95'd0, e.last, e.d});
                        if (m_last_o) last_hs_cyc = cyc;
                    end
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_valid = m_valid_o;
                prev_kl    = key_loaded_o;
                prev_last  = m_last_o;
                prev_d     = m_data_o;
            end
        end
    end

    int pt_first_cyc, pt_last_cyc;

    task automatic send_key(input logic [127:0] k);
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            @(negedge clk);
            key_valid_i = 1'b1;
            key_data_i  = k[127-32*i -: 32];
            while (!key_ready_o && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) check("key_ready_timeout", 128'(n), 128'(0));
        end
        @(negedge clk);
        key_valid_i = 1'b0;
    endtask

    task automatic send_pt(input logic [127:0] p);
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            @(negedge clk);
            s_valid_i = 1'b1;
            s_data_i  = p[127-32*i -: 32];
            while (!s_ready_o && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) check("s_ready_timeout", 128'(n), 128'(0));
            if (i == 0) pt_first_cyc = cyc;
            if (i == 3) pt_last_cyc = cyc;
        end
        @(negedge clk);
        s_valid_i = 1'b0;
    endtask

    task automatic wait_start(input int s0);
        int n = 0;
        while (start_cnt == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("start_timeout", 128'(start_cnt), 128'(s0 + 1));
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 128'(q.size()), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {121'd0, key_ready_o, s_ready_o, m_valid_o, m_last_o, err_o, key_loaded_o, core_start_o}, 128'd0);
        check({name, "_mdata"}, 128'(m_data_o), 128'd0);
        check({name, "_ckey"}, core_key_o, 128'd0);
        check({name, "_cpt"}, core_pt_o, 128'd0);
    endtask

    initial begin
        logic [127:0] k, p, p2;
        int           s0, exp_starts, n, err_cyc, hs_before;
        exp_starts = 0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {126'd0, key_ready_o, s_ready_o}, 128'd3);

        // FIPS-197 reference block
        stub_lat = 3;
        s0 = start_cnt;
        send_key(FIPS_K);
        check("key_loaded", 128'(key_loaded_o), 128'd1);
        send_pt(FIPS_P);
        push_block(FIPS_C);
        exp_starts++;
        wait_start(s0);
        check("start_latency", 128'(start_cyc), 128'(pt_last_cyc + 1));
        wait_empty();
        check("fips_one_start", 128'(start_cnt), 128'(s0 + 1));
        k = FIPS_K;

        // Random blocks under backpressure; first one has done on the timeout cycle
        bp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stub_lat = (i == 0) ? TMO - 1 : $urandom_range(1, TMO - 2);
            p = {$urandom, $urandom, $urandom, $urandom};
            if (i != 1) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                fork
                    send_key(k);
                    send_pt(p);
                join
            end else begin
                send_pt(p);
            end
            push_block(ref_ct(k, p));
            exp_starts++;
            wait_empty();
            check("no_err_normal", 128'(err_o), 128'd0);
        end

        // Back-to-back blocks under one key
        p  = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        stub_lat = 2;
        send_pt(p);
        push_block(ref_ct(k, p));
        send_pt(p2);
        hs_before = last_hs_cyc;
        push_block(ref_ct(k, p2));
        exp_starts += 2;
        check("b2b_after_last", 128'(pt_first_cyc > hs_before), 128'd1);
        wait_empty();
        bp_en = 1'b0;

        // Watchdog timeout with a hung core
        stub_lat = 0;
        send_pt({$urandom, $urandom, $urandom, $urandom});
        exp_starts++;
        n = 0;
        while (!err_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        check("err_set", 128'(err_o), 128'd1);
        check("err_timing", 128'(err_cyc - start_cyc), 128'(TMO + 1));
        check("tmo_s_ready", 128'(s_ready_o), 128'd1);
        check("tmo_key_kept", 128'(key_loaded_o), 128'd1);
        check("tmo_no_valid", 128'(m_valid_o), 128'd0);
        stub_kick = 1'b1;
        @(negedge clk);
        stub_kick = 1'b0;

        // Error flag does not block a following block
        stub_lat = 2;
        p = {$urandom, $urandom, $urandom, $urandom};
        send_pt(p);
        push_block(ref_ct(k, p));
        exp_starts++;
        wait_empty();
        check("err_sticky", 128'(err_o), 128'd1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        #1;
        check("err_cleared", 128'(err_o), 128'd0);

        // Reset during BUSY
        stub_lat = 0;
        s0 = start_cnt;
        send_pt({$urandom, $urandom, $urandom, $urandom});
        exp_starts++;
        wait_start(s0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_busy");
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_restart", 128'(start_cnt), 128'(s0 + 1));
        check("rst_key_cleared", 128'(key_loaded_o), 128'd0);

        // Plaintext before key after reset
        stub_lat = 3;
        s0 = start_cnt;
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        send_pt(p);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i % 3 == 0) check("wait_key_s_ready", 128'(s_ready_o), 128'd0);
        end
        check("wait_key_no_start", 128'(start_cnt), 128'(s0));
        send_key(k);
        push_block(ref_ct(k, p));
        exp_starts++;
        wait_start(s0);
        check("start_after_key", 128'(start_cyc), 128'(kl_cyc + 1));
        wait_empty();

        check("total_starts", 128'(start_cnt), 128'(exp_starts));
        check("queue_empty", 128'(q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/aes128_word_if.md
Name: aes128_word_if

Overview:
- Word-serial front end for the AES-128 encryption core. Sits directly upstream and downstream of it.
- Assembles a 128-bit key and a 128-bit plaintext block from 32-bit bus writes, then pulses the core's start.
- Captures the ciphertext on the core's done pulse and streams it back as four 32-bit words over a valid/ready interface.
- Adds a busy-timeout watchdog with a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY waiting for core done before aborting. Legal range is 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_valid_i  in  1  key word write strobe
- key_data_i  in  32  key word
- key_ready_o  out  1  key word accepted when high with key_valid_i
- s_valid_i  in  1  plaintext word valid
- s_data_i  in  32  plaintext word
- s_ready_o  out  1  plaintext word accepted
- m_valid_o  out  1  ciphertext word valid
- m_data_o  out  32  ciphertext word
- m_last_o  out  1  marks 4th ciphertext word
- m_ready_i  in  1  sink accepts word
- key_loaded_o  out  1  full 128-bit key held
- err_o  out  1  sticky core-timeout error
- err_clr_i  in  1  clears err_o
- core_start_o  out  1  one-cycle start pulse to core
- core_key_o  out  128  key to core
- core_pt_o  out  128  plaintext to core
- core_ready_i  in  1  core idle
- core_done_i  in  1  core done pulse
- core_ct_i  in  128  core ciphertext, valid in the core_done_i cycle

Behaviour:
- Reset values: all outputs 0; the FSM is in IDLE.
- Word order: the first word of each 4-word group maps to bits [127:96] and the last word to [31:0]. This applies to key, plaintext and ciphertext.
- FSM states: IDLE, START, BUSY, DRAIN.
- IDLE:
  - key_ready_o = 1.
  - s_ready_o = 1 while pt_cnt < 4.
  - A key write shifts the key register and increments key_cnt (2-bit).
  - The first word of a new key (key_cnt == 0) clears key_loaded_o.
  - The 4th word sets key_loaded_o in the cycle after acceptance, and key_cnt wraps to 0.
  - A plaintext write fills the buffer and increments pt_cnt (0..4).
  - Key and plaintext writes in the same cycle are both accepted.
  - IDLE -> START when pt_cnt == 4 && key_loaded_o && core_ready_i.
  - Plaintext complete without a loaded key: hold in IDLE with s_ready_o = 0.
- START:
  - core_start_o = 1 for exactly this cycle; key_ready_o = 0, s_ready_o = 0.
  - core_key_o and core_pt_o are driven directly from the internal registers and stay stable throughout START/BUSY.
  - Always -> BUSY next cycle. The timeout counter is cleared.
- BUSY:
  - The timeout counter increments each cycle.
  - On core_done_i, capture core_ct_i into the output buffer and go -> DRAIN.
  - If the counter reaches TIMEOUT_CYCLES without done: set err_o, clear pt_cnt, go -> IDLE. The key is retained.
  - If core_done_i and the timeout coincide, done wins (no error).
- DRAIN:
  - m_valid_o = 1 and m_data_o = the current word; o_cnt counts 0..3.
  - m_last_o = 1 when o_cnt == 3.
  - Under backpressure (m_ready_i = 0), m_data_o, m_last_o and m_valid_o hold stable.
  - On acceptance of the last word: go -> IDLE, pt_cnt cleared, m_valid_o = 0 next cycle.
  - Inputs are not accepted in DRAIN; s_ready_o rises the cycle after return to IDLE.
- Latency: last plaintext word accepted at cycle T (key loaded, core ready):
  - START at T+1;
  - first ciphertext word valid 1 cycle after core_done_i.
- Error handling:
  - err_o is sticky and cleared only by err_clr_i or reset.
  - err_clr_i and a new timeout in the same cycle: the set wins.
  - err_o does not block operation.
- Reset mid-operation (any state): all registers are cleared immediately, including key_loaded_o, counters, and the partial plaintext and ciphertext buffers. No output pulse follows.
- The key persists across blocks until a new 4-word key is written, so multiple blocks can run under one key.

Decomposition:
- Package aes_pkg:
  - word-interface state enum typedef (IDLE, START, BUSY, DRAIN);
  - AES_BLOCK_W = 128, AES_WORD_W = 32, AES_WORDS = 4;
  - shared with the core.
- No sub-module is required. Word packing and unpacking are plain shift registers.
- An integration wrapper, aes128_word_top, instantiating this block plus the core is natural but is a separate deliverable.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c; plaintext words 3243f6a8, 885a308d, 313198a2, e0370734.
  - Required response: output words 3925841d, 02dc09fb, dc118597, 196a0b32, with m_last_o on the 4th word; exactly one core_start_o pulse.
- Plaintext before key: write 4 plaintext words, then the key 10 cycles later.
  - No start until key_loaded_o = 1; s_ready_o = 0 while waiting.
  - Start 1 cycle after key_loaded_o rises; correct ciphertext.
- Backpressure: m_ready_i toggling 0/1 randomly during DRAIN.
  - Words emitted in order, with no duplication or loss; data stable while m_ready_i = 0.
- Timeout: a core stub that never asserts done, with TIMEOUT_CYCLES = 8.
  - err_o = 1 after 8 BUSY cycles; FSM back in IDLE; s_ready_o = 1; key_loaded_o still 1.
  - err_clr_i clears err_o.
- Reset mid-BUSY: assert rst_n = 0 during BUSY.
  - All outputs 0 immediately; key_loaded_o = 0.
  - No m_valid_o after release; a new full load works.
- Back-to-back blocks under one key: two plaintext blocks.
  - Two correct ciphertexts; the key is not rewritten.
  - The second block's input is accepted only after the first block's m_last_o handshake.
